hc194_shift_reg: RTL and testbench

- Parametrised successor to the dual D flip-flop block: a WIDTH-bit universal shift register in the 74HC194 style.
- Modes: hold, shift up, shift down and parallel load, selected per clock.
- Provides complementary Q/QN outputs, optional rotate mode, and a shift counter with a Done flag for serialiser/deserialiser use.
- Sits between the pad ring and downstream glue logic, the same place the discrete-logic emulation blocks occupy.

---
 rtl/hc_pkg.sv | 12 +
 rtl/hc_sat_counter.sv | 42 ++++
 rtl/hc194_shift_reg.sv | 89 ++++++++
 tb/tb_hc194_shift_reg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// Shared definitions for the HC-family discrete-logic emulation blocks.
// Mode encoding matches the 74HC194 S1:S0 select pins.
package hc_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHUP = 2'b01,
    MODE_SHDN = 2'b10,
    MODE_LOAD = 2'b11
  } hc_mode_e;

endpackage : hc_pkg

// File: rtl/hc_sat_counter.sv
// Saturating up-counter with synchronous clear; done flags the ceiling value.
// Used to count serial shifts since the last load or clear.
module hc_sat_counter #(
  parameter int CNT_W = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: async active-low reset with non-blocking updates; every flop here holds state, so all are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CntMax);

endmodule : hc_sat_counter

// File: rtl/hc194_shift_reg.sv
// WIDTH-bit 74HC194-style universal shift register with optional rotate,
// complementary outputs and a saturating shift counter for SerDes framing.
module hc194_shift_reg
  import hc_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ROTATE = 0,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             RD,
  input  logic             En,
  input  logic             SCLR,
  input  logic [1:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic [CNT_W-1:0] ShCnt,
  output logic             Done
);

  localparam bit RotEn = (ROTATE != 0);

  hc_mode_e         mode;
  logic             up_in;
  logic             dn_in;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign mode  = hc_mode_e'(S);
  // In rotate mode the serial pins are ignored and the shifted-out bit wraps.
  assign up_in = RotEn ? q_q[WIDTH-1] : DSR;
  assign dn_in = RotEn ? q_q[0]       : DSL;

  always_comb begin
    q_d     = q_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (SCLR) begin
      q_d     = '0;
      cnt_clr = 1'b1;
    end else if (En) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHUP: begin
          q_d     = {q_q[WIDTH-2:0], up_in};
          cnt_inc = 1'b1;
        end
        MODE_SHDN: begin
          q_d     = {dn_in, q_q[WIDTH-1:1]};
          cnt_inc = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = D;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge RD) begin
    if (!RD) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  hc_sat_counter #(
    .CNT_W(CNT_W),
    .MAX  (WIDTH)
  ) u_sat_counter (
    .clk  (Clk),
    .rst_n(RD),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (ShCnt),
    .done (Done)
  );

  // QN is derived from the same flops so it can never disagree with Q.
  assign Q  = q_q;
  assign QN = ~q_q;

endmodule : hc194_shift_reg

// File: tb/tb_hc194_shift_reg.sv
// Self-checking bench: a shift-only and a rotate instance driven in parallel,
// directed scenarios followed by a randomized regression against an integer model.
module tb_hc194_shift_reg;

  localparam int W    = 4;
  localparam int CW   = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;

  logic          clk;
  logic          rd;
  logic          en;
  logic          sclr;
  logic [1:0]    s;
  logic          dsr;
  logic          dsl;
  logic [W-1:0]  d;

  logic [W-1:0]  q0, qn0, q1, qn1;
  logic [CW-1:0] cnt0, cnt1;
  logic          done0, done1;

  int checks;
  int errors;
  int mq[2];
  int mc[2];

  hc194_shift_reg #(.WIDTH(W), .ROTATE(0)) dut_shift (
    .Clk(clk), .RD(rd), .En(en), .SCLR(sclr), .S(s), .DSR(dsr), .DSL(dsl), .D(d),
    .Q(q0), .QN(qn0), .ShCnt(cnt0), .Done(done0)
  );

  hc194_shift_reg #(.WIDTH(W), .ROTATE(1)) dut_rot (
    .Clk(clk), .RD(rd), .En(en), .SCLR(sclr), .S(s), .DSR(dsr), .DSL(dsl), .D(d),
    .Q(q1), .QN(qn1), .ShCnt(cnt1), .Done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: integer shift arithmetic with a saturating count.
  task automatic model_edge();
    for (int r = 0; r < 2; r++) begin
      int bit_in;
      if (sclr) begin
        mq[r] = 0;
        mc[r] = 0;
      end else if (en) begin
        case (s)
          2'd1: begin
            bit_in = (r == 1) ? ((mq[r] >> (W - 1)) & 1) : int'(dsr);
            mq[r]  = ((mq[r] * 2) + bit_in) & MASK;
            mc[r]  = (mc[r] < W) ? mc[r] + 1 : W;
          end
          2'd2: begin
            bit_in = (r == 1) ? (mq[r] & 1) : int'(dsl);
            mq[r]  = (mq[r] / 2) + bit_in * (1 << (W - 1));
            mc[r]  = (mc[r] < W) ? mc[r] + 1 : W;
          end
          2'd3: begin
            mq[r] = int'(d);
            mc[r] = 0;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q0"},    32'(q0),    32'(mq[0]));
    check({tag, ".qn0"},   32'(qn0),   32'((~mq[0]) & MASK));
    check({tag, ".cnt0"},  32'(cnt0),  32'(mc[0]));
    check({tag, ".done0"}, 32'(done0), 32'(mc[0] == W));
    check({tag, ".q1"},    32'(q1),    32'(mq[1]));
    check({tag, ".qn1"},   32'(qn1),   32'((~mq[1]) & MASK));
    check({tag, ".cnt1"},  32'(cnt1),  32'(mc[1]));
    check({tag, ".done1"}, 32'(done1), 32'(mc[1] == W));
  endtask

  // Inputs are applied 1 time unit after an edge, and outputs are sampled 1 unit after the next one.
  task automatic step(input logic [1:0] s_i, input logic en_i, input logic sclr_i,
                      input logic [W-1:0] d_i, input logic dsr_i, input logic dsl_i);
    s = s_i; en = en_i; sclr = sclr_i; d = d_i; dsr = dsr_i; dsl = dsl_i;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic pulse_reset();
    #1 rd = 1'b0;
    #1;
    mq[0] = 0; mq[1] = 0; mc[0] = 0; mc[1] = 0;
    compare_all("rst");
    #2 rd = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd = 1'b0; en = 1'b0; sclr = 1'b0; s = 2'b00; d = '0; dsr = 1'b0; dsl = 1'b0;
    mq[0] = 0; mq[1] = 0; mc[0] = 0; mc[1] = 0;
    #2;
    check("por.q0", 32'(q0), 32'h0);
    check("por.qn0", 32'(qn0), 32'hF);
    @(posedge clk); #1 rd = 1'b1;

    // Load 0xA, then reset mid-cycle.
    step(2'b11, 1'b1, 1'b0, 4'hA, 1'b0, 1'b0);
    check("ld_a.q0", 32'(q0), 32'hA);
    pulse_reset();
    check("rst.qn0", 32'(qn0), 32'hF);
    step(2'b11, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    check("ld5.q0", 32'(q0), 32'h5);
    check("ld5.qn0", 32'(qn0), 32'hA);
    compare_all("ld5");

    // Shift up with DSR=1 through saturation.
    step(2'b11, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(2'b01, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      check("shup.q0", 32'(q0), 32'((1 << (i > 4 ? 4 : i)) - 1));
      check("shup.cnt0", 32'(cnt0), 32'(i > 4 ? 4 : i));
      check("shup.done0", 32'(done0), 32'(i >= 4));
      compare_all("shup");
    end

    // Shift down from 0x8, then a load drops Done on the same edge.
    step(2'b11, 1'b1, 1'b0, 4'h8, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(2'b10, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
      check("shdn.q0", 32'(q0), 32'(8 >> i));
      compare_all("shdn");
    end
    step(2'b10, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("shdn4.done0", 32'(done0), 32'h1);
    step(2'b11, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    check("ld3.cnt0", 32'(cnt0), 32'h0);
    check("ld3.done0", 32'(done0), 32'h0);
    compare_all("ld3");

    // Rotate instance ignores the serial pins.
    step(2'b11, 1'b1, 1'b0, 4'b1001, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    check("rot_up.q1", 32'(q1), 32'b0011);
    step(2'b10, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    check("rot_dn1.q1", 32'(q1), 32'b1001);
    step(2'b10, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    check("rot_dn2.q1", 32'(q1), 32'b1100);
    compare_all("rot");

    // Priority: enable low holds, clear beats enable, hold mode is inert.
    step(2'b01, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    check("en0.q1", 32'(q1), 32'b1100);
    compare_all("en0");
    step(2'b11, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
    check("sclr.q0", 32'(q0), 32'h0);
    check("sclr.cnt1", 32'(cnt1), 32'h0);
    compare_all("sclr");
    step(2'b11, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(2'b00, 1'b1, 1'b0, 4'h9, 1'b1, 1'b1);
      check("hold.q0", 32'(q0), 32'h6);
      compare_all("hold");
    end

    // Randomized regression with occasional asynchronous resets.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        step(2'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
             W'($urandom), 1'($urandom), 1'($urandom));
        compare_all("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hc194_shift_reg
